mem_stage_sram_ctrl: RTL and testbench

Memory stage of the 5-stage ARM pipeline. It sits directly downstream of the execute stage and consumes its ALU result as the data address and valRm as the store data. It performs multi-cycle word accesses to an external single-port SRAM. While an access is in flight it asserts freeze to stall all upstream pipeline registers.

---
 rtl/mem_stage_sram_ctrl_if.sv | 37 +++
 rtl/mem_stage_sram_ctrl.sv | 94 +++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Memory-stage bus bundle: pipeline-side request/stall signals plus the
// external single-port SRAM signals.
//   slave  : memory-stage controller (consumes requests, drives SRAM)
//   master : pipeline + SRAM side (issues requests, returns read data)
// Signals:
//   memReadEn/memWriteEn  load/store request from EXE/MEM register
//   resultALU             byte address, valRm store data
//   freeze                stall upstream stages (combinational)
//   memResult/memDone     load data (registered) and completion pulse
//   sramAddr/sramWrData   SRAM word address / write data (registered)
//   sramRdData            SRAM read data
//   sramWeN               SRAM write enable, active-low
interface mem_stage_sram_ctrl_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              memReadEn;
   logic              memWriteEn;
   logic [31:0]       resultALU;
   logic [31:0]       valRm;
   logic              freeze;
   logic [31:0]       memResult;
   logic              memDone;
   logic [ADDR_W-1:0] sramAddr;
   logic [31:0]       sramWrData;
   logic [31:0]       sramRdData;
   logic              sramWeN;

   modport slave (
      input  memReadEn, memWriteEn, resultALU, valRm, sramRdData,
      output freeze, memResult, memDone, sramAddr, sramWrData, sramWeN
   );

   modport master (
      output memReadEn, memWriteEn, resultALU, valRm, sramRdData,
      input  freeze, memResult, memDone, sramAddr, sramWrData, sramWeN
   );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage of the 5-stage ARM pipeline. Performs multi-cycle word
// accesses to an external single-port SRAM and stalls upstream stages
// (freeze) while an access is in flight.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mem_stage_sram_ctrl_if.slave (request, stall, SRAM signals)
// Sequence per access: IDLE (request seen, address latched) ->
// WAIT_CYCLES x BUSY -> DONE (memDone pulse, freeze low) -> IDLE.
module mem_stage_sram_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned ADDR_W      = 16
) (
   input logic                    clk,
   input logic                    rst,
   mem_stage_sram_ctrl_if.slave   bus
);
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] cnt;
   logic             isWrite;
   logic             req;
   logic             lastCnt;

   assign req     = bus.memReadEn | bus.memWriteEn;
   assign lastCnt = (cnt == LAST_CNT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (req) stateNext = BUSY;
         BUSY:    if (lastCnt) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Combinational outputs; freeze drops in DONE so the pipeline advances
   // at the end of the completion cycle.
   always_comb begin
      bus.freeze  = req && (state != DONE);
      bus.memDone = (state == DONE);
   end

   // Registered datapath and SRAM interface
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         isWrite        <= 1'b0;
         bus.memResult  <= '0;
         bus.sramAddr   <= '0;
         bus.sramWrData <= '0;
         bus.sramWeN    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // Both enables high resolves to a store.
                  isWrite        <= bus.memWriteEn;
                  bus.sramWeN    <= ~bus.memWriteEn;
                  bus.sramAddr   <= ADDR_W'((bus.resultALU - 32'(BASE_ADDR)) >> 2);
                  bus.sramWrData <= bus.valRm;
                  cnt            <= '0;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (lastCnt) begin
                  if (!isWrite) bus.memResult <= bus.sramRdData;
                  bus.sramWeN <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: transaction-level reference
// model (access age counter + word array) compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_stage_sram_ctrl;
   localparam int unsigned BASE = 1024;
   localparam int unsigned W    = 5;
   localparam int unsigned AW   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_stage_sram_ctrl_if #(.ADDR_W(AW)) bus ();

   mem_stage_sram_ctrl #(
      .BASE_ADDR  (BASE),
      .WAIT_CYCLES(W),
      .ADDR_W     (AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;
   bit chkEn  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM stub driven by the DUT's SRAM pins
   logic [31:0] sram [0:(1<<AW)-1];
   assign bus.sramRdData = sram[bus.sramAddr];
   always @(posedge clk)
      if (chkEn && bus.sramWeN === 1'b0) sram[bus.sramAddr] <= bus.sramWrData;

   // Reference model: an accepted access is "age" cycles old; ages 1..W are
   // the SRAM cycles, age W+1 is the completion cycle.
   logic [31:0]   mMem [0:(1<<AW)-1];
   bit            active = 1'b0;
   int            age    = 0;
   bit            isW    = 1'b0;
   logic [AW-1:0] eAddr  = '0;
   logic [31:0]   eWr    = '0;
   logic [31:0]   eRes   = '0;

   function automatic logic [AW-1:0] wordAddr(input logic [31:0] a);
      logic [31:0] t;
      t = (a - BASE) / 4;
      return AW'(t % (1 << AW));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         active = 1'b0; age = 0; eAddr = '0; eWr = '0; eRes = '0;
      end else if (!active) begin
         if (bus.memReadEn || bus.memWriteEn) begin
            active = 1'b1;
            age    = 1;
            isW    = bus.memWriteEn;
            eAddr  = wordAddr(bus.resultALU);
            eWr    = bus.valRm;
            if (isW) mMem[eAddr] = eWr;
         end
      end else if (age == W + 1) begin
         active = 1'b0;
      end else begin
         if (age == W && !isW) eRes = mMem[eAddr];
         age++;
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         bit req, busy, done;
         req  = bus.memReadEn || bus.memWriteEn;
         busy = active && age >= 1 && age <= W;
         done = active && age == W + 1;
         chk("freeze",     32'(bus.freeze),  32'(req && !done));
         chk("memDone",    32'(bus.memDone), 32'(done));
         chk("sramWeN",    32'(bus.sramWeN), 32'(!(busy && isW)));
         chk("sramAddr",   32'(bus.sramAddr), 32'(eAddr));
         chk("sramWrData", bus.sramWrData,   eWr);
         chk("memResult",  bus.memResult,    eRes);
      end
   end

   task automatic setIn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      bus.memReadEn  = rd;
      bus.memWriteEn = wr;
      bus.resultALU  = a;
      bus.valRm      = d;
   endtask

   // Presents a request and follows it to memDone (bounded).
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int doneIdx, output int frz, output int wlow,
                         output logic [31:0] addr1, output logic [31:0] resDone);
      @(posedge clk); #1;
      setIn(rd, wr, a, d);
      doneIdx = -1; frz = 0; wlow = 0; addr1 = '0; resDone = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.freeze) frz++;
         if (bus.sramWeN === 1'b0) wlow++;
         if (i == 1) addr1 = 32'(bus.sramAddr);
         if (bus.memDone === 1'b1) begin
            doneIdx = i;
            resDone = bus.memResult;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      setIn(1'b0, 1'b0, '0, '0);
      for (int i = 1; i < n; i++) @(posedge clk);
   endtask

   initial begin
      int dIdx, dIdx2, frz, wlow;
      logic [31:0] a1, res;

      for (int i = 0; i < (1 << AW); i++) begin
         sram[i] = 32'(i) * 32'h9E37_79B1;
         mMem[i] = 32'(i) * 32'h9E37_79B1;
      end
      setIn(1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      @(posedge clk); #1;
      chkEn = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_freeze", 32'(bus.freeze), 32'd0);
      chk("rst_memDone", 32'(bus.memDone), 32'd0);
      chk("rst_weN", 32'(bus.sramWeN), 32'd1);
      chk("rst_addr", 32'(bus.sramAddr), 32'd0);
      chk("rst_memResult", bus.memResult, 32'd0);

      // Idle 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_quiet", {29'd0, bus.freeze, bus.memDone, bus.sramWeN}, 32'd1);
      end

      // Store
      access(1'b0, 1'b1, 32'd1024 + 32'h10, 32'hDEAD_BEEF, dIdx, frz, wlow, a1, res);
      chk("st_doneIdx", 32'(dIdx), 32'd6);
      chk("st_freezeCycles", 32'(frz), 32'd6);
      chk("st_weLowCycles", 32'(wlow), 32'd5);
      chk("st_addr", a1, 32'd4);
      chk("st_wrData", bus.sramWrData, 32'hDEAD_BEEF);
      idle(2);

      // Load back
      access(1'b1, 1'b0, 32'd1024 + 32'h10, 32'h0, dIdx, frz, wlow, a1, res);
      chk("ld_doneIdx", 32'(dIdx), 32'd6);
      chk("ld_weLowCycles", 32'(wlow), 32'd0);
      chk("ld_result", res, 32'hDEAD_BEEF);
      idle(2);

      // Back-to-back load then store: 7 + 7 cycles
      access(1'b1, 1'b0, 32'd1024 + 32'h10, 32'h0, dIdx, frz, wlow, a1, res);
      access(1'b0, 1'b1, 32'd1024 + 32'h20, 32'hCAFE_0001, dIdx2, frz, wlow, a1, res);
      chk("b2b_total", 32'(dIdx + 1 + dIdx2 + 1), 32'd14);
      chk("b2b_freeze2", 32'(frz), 32'd6);
      idle(2);

      // Boundary address, both enables -> store, memResult unchanged
      access(1'b1, 1'b1, 32'h0, 32'h1234_5678, dIdx, frz, wlow, a1, res);
      chk("bnd_addr", a1, 32'h0000_FF00);
      chk("bnd_weLowCycles", 32'(wlow), 32'd5);
      chk("bnd_result", res, 32'hDEAD_BEEF);
      idle(2);

      // Reset mid-BUSY of a write
      @(posedge clk); #1;
      setIn(1'b0, 1'b1, 32'd1024 + 32'h40, 32'h5555_AAAA);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      setIn(1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstb_weN", 32'(bus.sramWeN), 32'd1);
      chk("rstb_freeze", 32'(bus.freeze), 32'd0);
      chk("rstb_memResult", bus.memResult, 32'd0);
      chk("rstb_memDone", 32'(bus.memDone), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         @(posedge clk); #1;
         rst = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         case ($urandom_range(0, 5))
            0, 1:    setIn(1'b1, 1'b0, a, $urandom);
            2, 3:    setIn(1'b0, 1'b1, a, $urandom);
            4:       setIn(1'b1, 1'b1, a, $urandom);
            default: setIn(1'b0, 1'b0, a, $urandom);
         endcase
      end
      @(posedge clk); #1;
      rst = 1'b0;
      setIn(1'b0, 1'b0, '0, '0);
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
